// File: rtl/uart_rx_ctrl.sv
// Sequences the UART Rx block (enable/stop at frame boundaries, idle-only config) and buffers received characters with their error flags.
// Latency: rx_done_i at cycle N is visible on rd_* / fifo_level_o at N+1; irq_o is registered from next-state values.
// Backpressure: valid/ready on the read side; pushes into a full buffer are dropped (FIFO) or overwrite (holding) and set overrun.
module uart_rx_ctrl #(
    parameter int MAX_UART_DATA_W = 8,
    parameter int TOTAL_CONF_W    = 5,
    parameter int FIFO_ADDR_W     = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       ctrl_rx_en_i,
    input  logic                       ctrl_fifo_en_i,
    input  logic [TOTAL_CONF_W-1:0]    ctrl_conf_i,
    input  logic [FIFO_ADDR_W-1:0]     ctrl_thresh_i,
    input  logic                       ctrl_flush_i,
    input  logic                       ctrl_err_clr_i,
    input  logic                       rx_done_i,
    input  logic                       rx_busy_i,
    input  logic                       rx_parity_err_i,
    input  logic                       rx_stop_err_i,
    input  logic [MAX_UART_DATA_W-1:0] rx_data_i,
    output logic                       rx_en_o,
    output logic [TOTAL_CONF_W-1:0]    rx_conf_o,
    output logic                       rx_fifo_en_o,
    output logic                       rx_fifo_full_o,
    output logic                       rd_valid_o,
    input  logic                       rd_ready_i,
    output logic [MAX_UART_DATA_W-1:0] rd_data_o,
    output logic                       rd_parity_err_o,
    output logic                       rd_stop_err_o,
    output logic [FIFO_ADDR_W:0]       fifo_level_o,
    output logic                       fifo_empty_o,
    output logic                       fifo_full_o,
    output logic                       overrun_err_o,
    output logic                       irq_o
);

    localparam int DEPTH   = 2 ** FIFO_ADDR_W;
    localparam int ENTRY_W = MAX_UART_DATA_W + 2;
    localparam int LVL_W   = FIFO_ADDR_W + 1;

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_ACTIVE   = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   conf_load;
    logic [TOTAL_CONF_W-1:0] conf_q;

    logic [ENTRY_W-1:0]     mem_q [DEPTH];
    logic [FIFO_ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]       level_q, level_d;
    logic                   fifo_en_q;
    logic                   overrun_q, overrun_d;
    logic                   irq_q, irq_d;

    logic                   flush, push, pop, full, valid;
    logic                   mem_we, overrun_set;
    logic [FIFO_ADDR_W-1:0] mem_waddr;
    logic [LVL_W-1:0]       eff_depth;
    logic [FIFO_ADDR_W-1:0] thresh_eff;
    logic [ENTRY_W-1:0]     head;

    // FSM state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= ST_OFF;
        else         state_q <= state_d;
    end

    // FSM next state: leave ACTIVE through STOPPING when a frame is in flight
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_OFF:      if (ctrl_rx_en_i) state_d = ST_ACTIVE;
            ST_ACTIVE:   if (!ctrl_rx_en_i) state_d = rx_busy_i ? ST_STOPPING : ST_OFF;
            ST_STOPPING: if (!rx_busy_i) state_d = ST_OFF;
            default:     state_d = ST_OFF;
        endcase
    end

    // FSM outputs: enable only in ACTIVE, config loads only while the line is idle
    always_comb begin
        rx_en_o   = 1'b0;
        conf_load = 1'b0;
        case (state_q)
            ST_OFF:    conf_load = ctrl_rx_en_i;
            ST_ACTIVE: begin
                rx_en_o   = 1'b1;
                conf_load = !rx_busy_i;
            end
            default: ;
        endcase
    end

    // Configuration register presented to the receive block
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)        conf_q <= '0;
        else if (conf_load) conf_q <= ctrl_conf_i;
    end

    assign rx_conf_o    = conf_q;
    assign rx_fifo_en_o = 1'b0;

    assign eff_depth  = ctrl_fifo_en_i ? LVL_W'(DEPTH) : LVL_W'(1);
    assign full       = (level_q == eff_depth);
    assign valid      = (level_q != '0);
    assign flush      = ctrl_flush_i || (ctrl_fifo_en_i != fifo_en_q);
    assign push       = rx_done_i;
    assign pop        = valid && rd_ready_i;
    assign thresh_eff = (ctrl_thresh_i == '0) ? FIFO_ADDR_W'(1) : ctrl_thresh_i;

    // Buffer control: flush wins, push+pop keeps level, full push drops or overwrites
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        mem_we      = 1'b0;
        mem_waddr   = wr_ptr_q;
        overrun_set = 1'b0;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else if (push && pop) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + FIFO_ADDR_W'(1);
            rd_ptr_d = rd_ptr_q + FIFO_ADDR_W'(1);
        end else if (push) begin
            if (!full) begin
                mem_we   = 1'b1;
                wr_ptr_d = wr_ptr_q + FIFO_ADDR_W'(1);
                level_d  = level_q + LVL_W'(1);
            end else begin
                overrun_set = 1'b1;
                if (!ctrl_fifo_en_i) begin
                    // holding register: newest character replaces the unread one
                    mem_we    = 1'b1;
                    mem_waddr = rd_ptr_q;
                end
            end
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + FIFO_ADDR_W'(1);
            level_d  = level_q - LVL_W'(1);
        end
    end

    // Sticky overrun: a new overrun in the same cycle beats the clear
    always_comb begin
        overrun_d = overrun_q;
        if (overrun_set)         overrun_d = 1'b1;
        else if (ctrl_err_clr_i) overrun_d = 1'b0;
    end

    // Interrupt computed from next-state values so it lines up with the level update
    always_comb begin
        irq_d = overrun_d;
        if (ctrl_fifo_en_i) irq_d = irq_d || (level_d >= {1'b0, thresh_eff});
        else                irq_d = irq_d || (level_d != '0);
    end

    // Pointer, level, flag and interrupt registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            fifo_en_q <= 1'b0;
            overrun_q <= 1'b0;
            irq_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            fifo_en_q <= ctrl_fifo_en_i;
            overrun_q <= overrun_d;
            irq_q     <= irq_d;
        end
    end

    // Entry storage, cleared on reset so the head reads zero when empty
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (mem_we) begin
            mem_q[mem_waddr] <= {rx_stop_err_i, rx_parity_err_i, rx_data_i};
        end
    end

    assign head            = mem_q[rd_ptr_q];
    assign rd_valid_o      = valid;
    assign rd_data_o       = head[MAX_UART_DATA_W-1:0];
    assign rd_parity_err_o = head[MAX_UART_DATA_W];
    assign rd_stop_err_o   = head[MAX_UART_DATA_W+1];
    assign fifo_level_o    = level_q;
    assign fifo_empty_o    = !valid;
    assign fifo_full_o     = full;
    assign rx_fifo_full_o  = full;
    assign overrun_err_o   = overrun_q;
    assign irq_o           = irq_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: enable/config sequencing, FIFO and holding buffer behaviour, stop sequence, irq.
// Inputs change 1ns after the rising edge; outputs are checked 1ns after the edge that consumed them.
// Read side is driven explicitly by the stimulus; no random backpressure.
module tb_uart_rx_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       ctrl_rx_en_i = 1'b0;
    logic       ctrl_fifo_en_i = 1'b1;
    logic [4:0] ctrl_conf_i = '0;
    logic [3:0] ctrl_thresh_i = '0;
    logic       ctrl_flush_i = 1'b0;
    logic       ctrl_err_clr_i = 1'b0;
    logic       rx_done_i = 1'b0;
    logic       rx_busy_i = 1'b0;
    logic       rx_parity_err_i = 1'b0;
    logic       rx_stop_err_i = 1'b0;
    logic [7:0] rx_data_i = '0;
    logic       rd_ready_i = 1'b0;

    logic       rx_en_o, rx_fifo_en_o, rx_fifo_full_o;
    logic [4:0] rx_conf_o;
    logic       rd_valid_o, rd_parity_err_o, rd_stop_err_o;
    logic [7:0] rd_data_o;
    logic [4:0] fifo_level_o;
    logic       fifo_empty_o, fifo_full_o, overrun_err_o, irq_o;

    int n_cmp = 0;
    int n_bad = 0;

    uart_rx_ctrl #(.MAX_UART_DATA_W(8), .TOTAL_CONF_W(5), .FIFO_ADDR_W(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ctrl_rx_en_i(ctrl_rx_en_i), .ctrl_fifo_en_i(ctrl_fifo_en_i),
        .ctrl_conf_i(ctrl_conf_i), .ctrl_thresh_i(ctrl_thresh_i),
        .ctrl_flush_i(ctrl_flush_i), .ctrl_err_clr_i(ctrl_err_clr_i),
        .rx_done_i(rx_done_i), .rx_busy_i(rx_busy_i),
        .rx_parity_err_i(rx_parity_err_i), .rx_stop_err_i(rx_stop_err_i),
        .rx_data_i(rx_data_i),
        .rx_en_o(rx_en_o), .rx_conf_o(rx_conf_o), .rx_fifo_en_o(rx_fifo_en_o),
        .rx_fifo_full_o(rx_fifo_full_o),
        .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i), .rd_data_o(rd_data_o),
        .rd_parity_err_o(rd_parity_err_o), .rd_stop_err_o(rd_stop_err_o),
        .fifo_level_o(fifo_level_o), .fifo_empty_o(fifo_empty_o),
        .fifo_full_o(fifo_full_o), .overrun_err_o(overrun_err_o), .irq_o(irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push(input logic [7:0] d, input logic par, input logic stp);
        rx_done_i       = 1'b1;
        rx_data_i       = d;
        rx_parity_err_i = par;
        rx_stop_err_i   = stp;
        step();
        rx_done_i       = 1'b0;
        rx_parity_err_i = 1'b0;
        rx_stop_err_i   = 1'b0;
    endtask

    task automatic pop_check(input logic [7:0] exp);
        check_eq("drain_data", {24'd0, rd_data_o}, {24'd0, exp});
        rd_ready_i = 1'b1;
        step();
        rd_ready_i = 1'b0;
    endtask

    initial begin
        // reset values
        #12;
        check_eq("rst_rx_en", rx_en_o, 0);
        check_eq("rst_conf", rx_conf_o, 0);
        check_eq("rst_empty", fifo_empty_o, 1);
        check_eq("rst_level", fifo_level_o, 0);
        check_eq("rst_valid", rd_valid_o, 0);
        check_eq("rst_full", fifo_full_o, 0);
        check_eq("rst_overrun", overrun_err_o, 0);
        check_eq("rst_irq", irq_o, 0);
        check_eq("rst_rx_fifo_en", rx_fifo_en_o, 0);
        step();
        rst_ni = 1'b1;
        step();

        // enable with idle line, then config must hold while busy
        ctrl_conf_i  = 5'b11011;
        ctrl_rx_en_i = 1'b1;
        check_eq("off_rx_en", rx_en_o, 0);
        step();
        check_eq("en_rx_en", rx_en_o, 1);
        check_eq("en_conf", rx_conf_o, 5'b11011);
        rx_busy_i   = 1'b1;
        ctrl_conf_i = 5'b00100;
        step();
        check_eq("busy_conf_hold1", rx_conf_o, 5'b11011);
        step();
        check_eq("busy_conf_hold2", rx_conf_o, 5'b11011);
        rx_busy_i = 1'b0;
        step();
        check_eq("idle_conf_upd", rx_conf_o, 5'b00100);

        // FIFO mode: fill to 16, then one more is dropped
        for (int i = 0; i < 16; i++) push(8'(i), 1'b0, 1'b0);
        check_eq("fill_level", fifo_level_o, 16);
        check_eq("fill_full", fifo_full_o, 1);
        check_eq("fill_rx_full", rx_fifo_full_o, 1);
        check_eq("fill_irq", irq_o, 1);
        check_eq("fill_overrun", overrun_err_o, 0);
        push(8'hAA, 1'b0, 1'b0);
        check_eq("drop_level", fifo_level_o, 16);
        check_eq("drop_overrun", overrun_err_o, 1);
        check_eq("drop_head", rd_data_o, 8'h00);
        ctrl_err_clr_i = 1'b1;
        step();
        ctrl_err_clr_i = 1'b0;
        check_eq("clr_overrun", overrun_err_o, 0);

        // full + simultaneous pop and push
        rd_ready_i = 1'b1;
        push(8'h55, 1'b0, 1'b0);
        rd_ready_i = 1'b0;
        check_eq("pp_level", fifo_level_o, 16);
        check_eq("pp_overrun", overrun_err_o, 0);
        check_eq("pp_head", rd_data_o, 8'h01);
        for (int i = 1; i < 16; i++) pop_check(8'(i));
        pop_check(8'h55);
        check_eq("drain_empty", fifo_empty_o, 1);
        check_eq("drain_irq", irq_o, 0);

        // holding mode
        ctrl_fifo_en_i = 1'b0;
        step();
        push(8'h11, 1'b0, 1'b0);
        check_eq("hold_valid", rd_valid_o, 1);
        check_eq("hold_irq1", irq_o, 1);
        push(8'h22, 1'b0, 1'b0);
        check_eq("hold_data", rd_data_o, 8'h22);
        check_eq("hold_level", fifo_level_o, 1);
        check_eq("hold_overrun", overrun_err_o, 1);
        check_eq("hold_irq2", irq_o, 1);
        ctrl_err_clr_i = 1'b1;
        push(8'h33, 1'b0, 1'b0);
        ctrl_err_clr_i = 1'b0;
        check_eq("set_beats_clr", overrun_err_o, 1);
        check_eq("hold_data3", rd_data_o, 8'h33);
        ctrl_err_clr_i = 1'b1;
        step();
        ctrl_err_clr_i = 1'b0;
        check_eq("hold_clr", overrun_err_o, 0);
        check_eq("hold_irq_valid", irq_o, 1);
        rd_ready_i = 1'b1;
        step();
        rd_ready_i = 1'b0;
        check_eq("hold_pop_valid", rd_valid_o, 0);
        check_eq("hold_pop_irq", irq_o, 0);

        // stop while busy, pending character still captured
        rx_busy_i    = 1'b1;
        ctrl_rx_en_i = 1'b0;
        step();
        check_eq("stop_rx_en", rx_en_o, 0);
        ctrl_rx_en_i = 1'b1;
        step();
        check_eq("stop_reen_ignored", rx_en_o, 0);
        push(8'h3C, 1'b0, 1'b1);
        check_eq("stop_cap_data", rd_data_o, 8'h3C);
        check_eq("stop_cap_stop", rd_stop_err_o, 1);
        check_eq("stop_cap_par", rd_parity_err_o, 0);
        rx_busy_i = 1'b0;
        step();
        check_eq("off_reached", rx_en_o, 0);
        step();
        check_eq("reenable", rx_en_o, 1);
        rd_ready_i = 1'b1;
        step();
        rd_ready_i = 1'b0;

        // threshold interrupt and flush priority
        ctrl_fifo_en_i = 1'b1;
        ctrl_thresh_i  = 4'd4;
        step();
        push(8'h01, 1'b1, 1'b0);
        check_eq("thr_parity", rd_parity_err_o, 1);
        check_eq("thr_irq1", irq_o, 0);
        push(8'h02, 1'b0, 1'b0);
        push(8'h03, 1'b0, 1'b0);
        check_eq("thr_irq3", irq_o, 0);
        push(8'h04, 1'b0, 1'b0);
        check_eq("thr_level4", fifo_level_o, 4);
        check_eq("thr_irq4", irq_o, 1);
        ctrl_flush_i = 1'b1;
        push(8'h05, 1'b0, 1'b0);
        ctrl_flush_i = 1'b0;
        check_eq("flush_level", fifo_level_o, 0);
        check_eq("flush_empty", fifo_empty_o, 1);
        check_eq("flush_irq", irq_o, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
- Controller that sequences and configures the UART Rx receive block and owns the Rx FIFO that replaces the receive block's internal push logic.
- Enables and disables the receiver cleanly at frame boundaries, changes Rx configuration only while the line is idle, and buffers received characters with their error flags.
- Presents buffered characters to the register interface through a valid/ready handshake, with overrun detection and a level interrupt.

Parameters:
- MAX_UART_DATA_W, 8, width of UART data
- TOTAL_CONF_W, 5, width of Rx configuration {data[1:0], stop[1:0], parity_en}
- FIFO_ADDR_W, 4, FIFO address width; depth = 2**FIFO_ADDR_W

Ports:
- clk_i  in  1  top clock
- rst_ni  in  1  asynchronous active-low reset
- ctrl_rx_en_i  in  1  software Rx enable
- ctrl_fifo_en_i  in  1  1 = FIFO mode, 0 = single holding register
- ctrl_conf_i  in  TOTAL_CONF_W  requested Rx configuration
- ctrl_thresh_i  in  FIFO_ADDR_W  IRQ level threshold
- ctrl_flush_i  in  1  flush pulse
- ctrl_err_clr_i  in  1  clear sticky overrun
- rx_done_i  in  1  1-cycle character-done pulse from the receive block
- rx_busy_i  in  1  receive block busy
- rx_parity_err_i  in  1  parity error for the current character
- rx_stop_err_i  in  1  stop error for the current character
- rx_data_i  in  MAX_UART_DATA_W  received data
- rx_en_o  out  1  receive block enable
- rx_conf_o  out  TOTAL_CONF_W  configuration to the receive block
- rx_fifo_en_o  out  1  tied to 0; the push path is owned here
- rx_fifo_full_o  out  1  copy of fifo_full_o
- rd_valid_o  out  1  head entry valid
- rd_ready_i  in  1  host accepts head
- rd_data_o  out  MAX_UART_DATA_W  head data
- rd_parity_err_o  out  1  head parity flag
- rd_stop_err_o  out  1  head stop flag
- fifo_level_o  out  FIFO_ADDR_W+1  entries stored
- fifo_empty_o  out  1  level == 0
- fifo_full_o  out  1  level == effective depth
- overrun_err_o  out  1  sticky overrun
- irq_o  out  1  registered interrupt

Behaviour:
- Reset:
  - All outputs 0 except fifo_empty_o = 1.
  - FSM = OFF; pointers, level and memory contents are cleared.
- FSM states: OFF, ACTIVE, STOPPING.
  - OFF: rx_en_o = 0. When ctrl_rx_en_i = 1: rx_conf_o <= ctrl_conf_i, go to ACTIVE; rx_en_o = 1 the cycle after entry.
  - ACTIVE: rx_en_o = 1. rx_conf_o <= ctrl_conf_i on every cycle where rx_busy_i = 0; it is held while busy.
  - ACTIVE exit on ctrl_rx_en_i = 0: go to STOPPING if rx_busy_i = 1, else go to OFF.
  - STOPPING: rx_en_o = 0 so the receive block returns to its Reset state at Done. rx_done_i is still captured. Go to OFF when rx_busy_i = 0.
  - ctrl_rx_en_i reasserting in STOPPING has no effect until OFF is reached.
- Entry word: {rx_stop_err_i, rx_parity_err_i, rx_data_i}, written on rx_done_i in any state.
  - Latency: rx_done_i at cycle N gives rd_valid_o and an updated fifo_level_o at N+1.
  - First-word fall-through: rd_* outputs show the head while rd_valid_o = 1.
- Pop occurs when rd_valid_o && rd_ready_i; rd_ready_i is ignored while rd_valid_o = 0.
- Effective depth is 2**FIFO_ADDR_W in FIFO mode and 1 in holding mode.
- Push while full:
  - FIFO mode: the new word is dropped and overrun_err_o is set.
  - Holding mode: the new word overwrites the slot and overrun_err_o is set.
  - If a pop happens in the same cycle, the push is accepted, the level is unchanged and no overrun is flagged.
- Flush: ctrl_flush_i, or any change of ctrl_fifo_en_i (edge detected), empties the FIFO the next cycle. Flush has priority over a simultaneous push or pop.
- overrun_err_o is sticky and cleared by ctrl_err_clr_i; set has priority over clear in the same cycle.
- Pointers wrap modulo 2**FIFO_ADDR_W. Level stays in 0..depth and is never wrapped.
- irq_o is registered and equals OR of:
  - fifo_level >= max(ctrl_thresh_i, 1) in FIFO mode;
  - rd_valid_o in holding mode;
  - overrun_err_o.
- Asynchronous reset mid-frame returns everything to reset values immediately; no partial entry is kept.

Test Plan:
- Enable with conf = 5'b11011, idle line → rx_en_o = 1 one cycle after OFF exit and rx_conf_o = 5'b11011. Change ctrl_conf_i while rx_busy_i = 1 → rx_conf_o unchanged until rx_busy_i falls.
- FIFO mode, 16 rx_done_i pulses with data 0x00..0x0F, rd_ready_i = 0 → level 16 and fifo_full_o = 1. A 17th pulse (0xAA) → dropped, overrun_err_o = 1, head still 0x00.
- Full FIFO, rx_done_i with data 0x55 and rd_ready_i = 1 in the same cycle → 0x00 popped, 0x55 stored, level stays 16, overrun_err_o stays 0.
- Holding mode, two pulses 0x11 then 0x22 without a read → rd_data_o = 0x22, overrun_err_o = 1, irq_o = 1. ctrl_err_clr_i with a simultaneous third pulse → overrun_err_o stays 1.
- ctrl_rx_en_i dropped while rx_busy_i = 1 → STOPPING with rx_en_o = 0. The pending rx_done_i (0x3C, stop_err = 1) is captured with rd_stop_err_o = 1, then OFF once busy clears.
- Threshold 4, 4 pushes → irq_o = 1 at the cycle after the 4th push. Flush with a simultaneous push → level = 0, irq_o = 0 the next cycle.
